// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU's stage-3 memory unit and the data memory.
// Built with DMEM_MMIO_EN defined, the bundle also carries io_out, the MMIO
// output register.
//   master (CPU side) : drives MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en
//                       samples MEM_data, mem_ready, acc_err (and io_out)
//   slave  (memory)   : the mirror image
interface data_mem_responder_if;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic [31:0] MEM_data;
  logic        mem_ready;
  logic [1:0]  acc_err;
`ifdef DMEM_MMIO_EN
  logic [31:0] io_out;
`endif

  modport master (
    output MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
    input  MEM_data, mem_ready, acc_err
`ifdef DMEM_MMIO_EN
    , input io_out
`endif
  );

  modport slave (
    input  MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
    output MEM_data, mem_ready, acc_err
`ifdef DMEM_MMIO_EN
    , output io_out
`endif
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory behind the CPU's stage-3 load/store port.
// - Single-port array of DEPTH_WORDS 32-bit words with byte lanes.
// - Loads are combinational. Stores commit at the next CLK edge.
// - After Reset a sweep writes zero to every word, one word per cycle.
//   Requests are ignored until the sweep is done (mem_ready=1).
// - Sticky fault flags acc_err: [0] misaligned, [1] out of range or illegal type.
// Ports:
//   CLK    clock, all state changes on posedge
//   Reset  synchronous, active-high
//   bus    data_mem_responder_if.slave
//          MEM_addr/MEM_WR_out/MEM_type/MEM_rd_en/MEM_wr_en in,
//          MEM_data/mem_ready/acc_err (and io_out) out
// Optional feature macro: DMEM_MMIO_EN
//   Adds a word-only MMIO output register at IO_ADDR, driven out on bus.io_out.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
  input logic                 CLK,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx;
  logic [IDX_W-1:0] w_sweep_idx_nxt;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [1:0]       r_acc_err;

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_in_range;
  logic             w_is_io;
  logic             w_is_half;
  logic             w_is_word;
  logic             w_ld_type_ok;
  logic             w_st_type_ok;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_req;
  logic             w_ok;
  logic             w_mis_flag;
  logic             w_ill_flag;
  logic             w_ld_go;
  logic             w_st_go;
  logic [31:0]      w_shifted;
  logic [31:0]      w_lane_data;
  logic [31:0]      w_mem_data;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;

  // ADDR_BASE is word aligned, so the low offset bits are the byte lane.
  assign w_off      = bus.MEM_addr - ADDR_BASE;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_lane     = w_off[1:0];
  // Addresses below ADDR_BASE wrap to a huge offset and fail this test too.
  assign w_in_range = (w_off[31:2] < 30'(DEPTH_WORDS));

`ifdef DMEM_MMIO_EN
  logic [31:0] r_io_out;

  assign w_is_io    = (bus.MEM_addr == IO_ADDR);
  assign bus.io_out = r_io_out;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_io_out <= '0;
    end else if (w_st_go && w_is_io) begin
      r_io_out <= bus.MEM_WR_out;
    end
  end
`else
  logic w_unused_io;

  assign w_is_io     = 1'b0;
  assign w_unused_io = ^IO_ADDR;
`endif

  // Sweep / ready state machine
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= S_CLEAR;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      S_CLEAR: begin
        w_sweep_idx_nxt = r_sweep_idx + 1'b1;
        if (r_sweep_idx == '1) begin
          w_state_nxt = S_READY;
        end
      end
      default: begin
        w_state_nxt = S_READY;
      end
    endcase
  end

  // Access classification
  always_comb begin
    w_is_half    = (bus.MEM_type == 3'b001) || (bus.MEM_type == 3'b101);
    w_is_word    = (bus.MEM_type == 3'b010);
    w_ld_type_ok = (bus.MEM_type != 3'b011) && (bus.MEM_type != 3'b110) &&
                   (bus.MEM_type != 3'b111);
    w_st_type_ok = (bus.MEM_type == 3'b000) || (bus.MEM_type == 3'b001) ||
                   (bus.MEM_type == 3'b010);
    w_misalign   = !w_is_io && ((w_is_half && w_lane[0]) ||
                                (w_is_word && (w_lane != 2'b00)));
    // The MMIO register accepts word accesses only and bypasses the range test.
    if (w_is_io) begin
      w_illegal = !w_is_word;
    end else begin
      w_illegal = !w_in_range || (bus.MEM_rd_en && !w_ld_type_ok) ||
                  (bus.MEM_wr_en && !w_st_type_ok);
    end
    w_req      = (r_state == S_READY) && (bus.MEM_rd_en || bus.MEM_wr_en);
    // A combined load+store is one access: any fault suppresses both halves
    // and is flagged once.
    w_ok       = w_req && !w_misalign && !w_illegal;
    w_mis_flag = w_req && w_misalign;
    w_ill_flag = w_req && w_illegal;
    w_ld_go    = w_ok && bus.MEM_rd_en;
    w_st_go    = w_ok && bus.MEM_wr_en;
  end

  // Load path: reads the array before any same-cycle store lands (read-old).
  always_comb begin
    w_shifted   = r_mem[w_idx] >> {w_lane, 3'b000};
    w_lane_data = '0;
    case (bus.MEM_type[1:0])
      2'b00:   w_lane_data = {24'h0, w_shifted[7:0]};
      2'b01:   w_lane_data = {16'h0, w_shifted[15:0]};
      default: w_lane_data = w_shifted;
    endcase
`ifdef DMEM_MMIO_EN
    if (w_is_io) begin
      w_lane_data = r_io_out;
    end
`endif
    w_mem_data = w_ld_go ? w_lane_data : '0;
  end

  assign bus.MEM_data  = w_mem_data;
  assign bus.mem_ready = (r_state == S_READY);
  assign bus.acc_err   = r_acc_err;

  // Store path: replicate the narrow datum to every lane, enable only its lanes.
  always_comb begin
    w_wdata = bus.MEM_WR_out;
    w_be    = 4'b1111;
    case (bus.MEM_type[1:0])
      2'b00: begin
        w_wdata = {4{bus.MEM_WR_out[7:0]}};
        w_be    = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_wdata = {2{bus.MEM_WR_out[15:0]}};
        w_be    = 4'b0011 << w_lane;
      end
      default: begin
        w_wdata = bus.MEM_WR_out;
        w_be    = 4'b1111;
      end
    endcase
  end

  // The array has no reset of its own; the sweep clears it instead.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_sweep_idx] <= '0;
      end else if (w_st_go && !w_is_io) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_be[b]) begin
            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_acc_err <= '0;
    end else begin
      r_acc_err <= r_acc_err | {w_ill_flag, w_mis_flag};
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH_WORDS=16), with a
// byte-addressed reference model of the memory, the sticky flags and io_out.
module tb_data_mem_responder;

  localparam int unsigned DEPTH      = 16;
  localparam logic [31:0] BASE_TB    = 32'h0000_0000;
  localparam logic [31:0] IO_ADDR_TB = 32'hFFFF_FFF0;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [2:0]  t;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic CLK;
  logic Reset;
  int   checks;
  int   failures;

  logic [7:0]  m_bytes [DEPTH*4];
  logic [1:0]  m_err;
  logic [31:0] m_io;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_BASE  (BASE_TB),
    .IO_ADDR    (IO_ADDR_TB)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: one request against the pre-edge state; returns the load
  // data and applies the store and fault flags.
  task automatic model_access(input logic [31:0] a, input logic [2:0] t,
                              input logic rd, input logic wr,
                              input logic [31:0] wd, output logic [31:0] exp);
    int unsigned nb;
    int unsigned off;
    bit io, inr, mis, ill, ldok, stok;
    exp = '0;
    if (!rd && !wr) return;
    case (t)
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 1;
    endcase
    off  = a - BASE_TB;
    inr  = (off / 4) < DEPTH;
    io   = MMIO && (a == IO_ADDR_TB);
    ldok = !(t == 3'd3 || t == 3'd6 || t == 3'd7);
    stok = (t <= 3'd2);
    mis  = !io && ((a % nb) != 0);
    ill  = io ? (t != 3'd2) : (!inr || (rd && !ldok) || (wr && !stok));
    if (mis) m_err[0] = 1'b1;
    if (ill) m_err[1] = 1'b1;
    if (mis || ill) return;
    if (rd) begin
      if (io) exp = m_io;
      else for (int i = 0; i < int'(nb); i++)
        exp = exp | ({24'h0, m_bytes[int'(off) + i]} << (8 * i));
    end
    if (wr) begin
      if (io) m_io = wd;
      else for (int i = 0; i < int'(nb); i++)
        m_bytes[int'(off) + i] = wd[8*i +: 8];
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] t,
                       input logic rd, input logic wr, input logic [31:0] wd);
    bus.MEM_addr   = a;
    bus.MEM_type   = t;
    bus.MEM_rd_en  = rd;
    bus.MEM_wr_en  = wr;
    bus.MEM_WR_out = wd;
  endtask

  // Drive a request in READY, let it settle, and run the model on it.
  task automatic step(input logic [31:0] a, input logic [2:0] t,
                      input logic rd, input logic wr, input logic [31:0] wd,
                      output logic [31:0] exp);
    drive(a, t, rd, wr, wd);
    #1;
    model_access(a, t, rd, wr, wd, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.MEM_rd_en = 1'b0;
    bus.MEM_wr_en = 1'b0;
  endtask

  task automatic apply_reset();
    drive(32'h0, 3'd2, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < int'(DEPTH * 4); i++) m_bytes[i] = 8'h00;
    m_err = 2'b00;
    m_io  = '0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    apply_reset();
    checks++;
    if (bus.acc_err !== 2'b00) begin
      failures++;
      $display("FAIL reset_acc_err got=%b want=00", bus.acc_err);
    end
    // A misaligned load held through the sweep must be ignored entirely.
    drive(32'h6, 3'd2, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < int'(DEPTH); k++) begin
      #1;
      checks++;
      if (bus.mem_ready !== 1'b0) begin
        failures++;
        $display("FAIL sweep_ready cycle=%0d got=%b want=0", k, bus.mem_ready);
      end
      checks++;
      if (bus.MEM_data !== 32'h0 || bus.acc_err !== 2'b00) begin
        failures++;
        $display("FAIL sweep_ignore cycle=%0d data=%h err=%b want=0/00", k, bus.MEM_data, bus.acc_err);
      end
      if (k == int'(DEPTH) - 1) bus.MEM_rd_en = 1'b0;
      @(posedge CLK);
    end
    #1;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL sweep_done got=%b want=1", bus.mem_ready);
    end
    for (int w = 0; w < int'(DEPTH); w++) begin
      step(32'(w * 4), 3'd2, 1'b1, 1'b0, 32'h0, exp);
      checks++;
      if (bus.MEM_data !== 32'h0) begin
        failures++;
        $display("FAIL cleared_word idx=%0d got=%h want=00000000", w, bus.MEM_data);
      end
      tick();
    end
  endtask

  task automatic test_directed();
    logic [31:0] exp;
    vec_t tbl [13];
    tbl = '{
      '{32'h8, 3'd2, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0},
      '{32'h8, 3'd2, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF},
      '{32'h9, 3'd0, 1'b1, 1'b0, 32'h0,        32'h000000BE},
      '{32'hA, 3'd5, 1'b1, 1'b0, 32'h0,        32'h0000DEAD},
      '{32'hA, 3'd1, 1'b1, 1'b0, 32'h0,        32'h0000DEAD},
      '{32'hB, 3'd0, 1'b0, 1'b1, 32'hFFFFFF55, 32'h0},
      '{32'h8, 3'd2, 1'b1, 1'b0, 32'h0,        32'h55ADBEEF},
      '{32'hB, 3'd4, 1'b1, 1'b0, 32'h0,        32'h00000055},
      '{32'h4, 3'd1, 1'b0, 1'b1, 32'hABCD1234, 32'h0},
      '{32'h4, 3'd2, 1'b1, 1'b0, 32'h0,        32'h00001234},
      '{32'hC, 3'd2, 1'b1, 1'b1, 32'h11112222, 32'h0},
      '{32'hC, 3'd2, 1'b1, 1'b0, 32'h0,        32'h11112222},
      '{32'h8, 3'd2, 1'b0, 1'b0, 32'h0,        32'h0}
    };
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].a, tbl[i].t, tbl[i].rd, tbl[i].wr, tbl[i].wd, exp);
      checks++;
      if (bus.MEM_data !== tbl[i].exp) begin
        failures++;
        $display("FAIL directed[%0d] addr=%h got=%h want=%h", i, tbl[i].a, bus.MEM_data, tbl[i].exp);
      end
      tick();
    end
    checks++;
    if (bus.acc_err !== 2'b00) begin
      failures++;
      $display("FAIL directed_acc_err got=%b want=00", bus.acc_err);
    end
  endtask

  task automatic test_faults();
    logic [31:0] exp;
    bit ok;
    step(32'h6, 3'd2, 1'b1, 1'b0, 32'h0, exp);
    checks++;
    if (bus.MEM_data !== 32'h0) begin
      failures++;
      $display("FAIL misaligned_data got=%h want=00000000", bus.MEM_data);
    end
    tick();
    checks++;
    if (bus.acc_err !== 2'b01) begin
      failures++;
      $display("FAIL misaligned_flag got=%b want=01", bus.acc_err);
    end
    step(32'h40, 3'd2, 1'b0, 1'b1, 32'h12345678, exp);
    tick();
    checks++;
    if (bus.acc_err !== 2'b11) begin
      failures++;
      $display("FAIL range_flag got=%b want=11", bus.acc_err);
    end
    // 0x40 aliases word 0 in the index bits; word 0 must be untouched.
    step(32'h0, 3'd2, 1'b1, 1'b0, 32'h0, exp);
    checks++;
    if (bus.MEM_data !== 32'h0) begin
      failures++;
      $display("FAIL range_no_write got=%h want=00000000", bus.MEM_data);
    end
    tick();
    apply_reset();
    checks++;
    if (bus.acc_err !== 2'b00) begin
      failures++;
      $display("FAIL reset_clears_flags got=%b want=00", bus.acc_err);
    end
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ready_timeout after_fault_reset got=0 want=1");
    end
  endtask

  task automatic test_reset_midsweep();
    logic [31:0] exp;
    apply_reset();
    for (int i = 0; i < 7; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (k == 2) drive(32'h0, 3'd2, 1'b0, 1'b1, 32'hCAFEF00D);
      else bus.MEM_wr_en = 1'b0;
      #1;
      checks++;
      if (bus.mem_ready !== 1'b0) begin
        failures++;
        $display("FAIL restart_ready cycle=%0d got=%b want=0", k, bus.mem_ready);
      end
      @(posedge CLK);
    end
    #1;
    bus.MEM_wr_en = 1'b0;
    checks++;
    if (bus.mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_done got=%b want=1", bus.mem_ready);
    end
    step(32'h0, 3'd2, 1'b1, 1'b0, 32'h0, exp);
    checks++;
    if (bus.MEM_data !== 32'h0) begin
      failures++;
      $display("FAIL clear_store_dropped got=%h want=00000000", bus.MEM_data);
    end
    tick();
  endtask

  task automatic test_mmio();
    logic [31:0] exp;
    bit ok;
    apply_reset();
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ready_timeout before_mmio got=0 want=1");
    end
`ifdef DMEM_MMIO_EN
    step(IO_ADDR_TB, 3'd2, 1'b0, 1'b1, 32'hA5A50001, exp);
    tick();
    checks++;
    if (bus.io_out !== 32'hA5A50001) begin
      failures++;
      $display("FAIL mmio_store got=%h want=A5A50001", bus.io_out);
    end
    step(IO_ADDR_TB, 3'd2, 1'b1, 1'b0, 32'h0, exp);
    checks++;
    if (bus.MEM_data !== 32'hA5A50001) begin
      failures++;
      $display("FAIL mmio_load got=%h want=A5A50001", bus.MEM_data);
    end
    tick();
    step(IO_ADDR_TB, 3'd0, 1'b0, 1'b1, 32'h000000FF, exp);
    tick();
    checks++;
    if (bus.acc_err !== 2'b10 || bus.io_out !== 32'hA5A50001) begin
      failures++;
      $display("FAIL mmio_byte err=%b io=%h want=10/A5A50001", bus.acc_err, bus.io_out);
    end
`else
    step(IO_ADDR_TB, 3'd2, 1'b0, 1'b1, 32'hA5A50001, exp);
    tick();
    checks++;
    if (bus.acc_err !== 2'b10) begin
      failures++;
      $display("FAIL io_addr_unmapped got=%b want=10", bus.acc_err);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp;
    logic [2:0]  t;
    logic        rd, wr;
    int unsigned r;
    bit ok;
    for (int batch = 0; batch < 4; batch++) begin
      apply_reset();
      wait_ready(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL ready_timeout batch=%0d got=0 want=1", batch);
      end
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      a = $urandom;
        else if (r == 1) a = IO_ADDR_TB;
        else if (r == 2) a = 32'h40 + 32'($urandom_range(0, 31));
        else             a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) t = 3'($urandom_range(0, 7));
        else case ($urandom_range(0, 4))
          0: t = 3'd0;
          1: t = 3'd1;
          2: t = 3'd2;
          3: t = 3'd4;
          default: t = 3'd5;
        endcase
        if (r >= 3 && $urandom_range(0, 5) != 0) begin
          if (t == 3'd2) a[1:0] = 2'b00;
          else if (t == 3'd1 || t == 3'd5) a[0] = 1'b0;
        end
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        step(a, t, rd, wr, wd, exp);
        checks++;
        if (bus.MEM_data !== exp) begin
          failures++;
          $display("FAIL rand_data addr=%h type=%0d rd=%b wr=%b got=%h want=%h", a, t, rd, wr, bus.MEM_data, exp);
        end
        tick();
        checks++;
        if (bus.acc_err !== m_err) begin
          failures++;
          $display("FAIL rand_acc_err addr=%h type=%0d got=%b want=%b", a, t, bus.acc_err, m_err);
        end
`ifdef DMEM_MMIO_EN
        checks++;
        if (bus.io_out !== m_io) begin
          failures++;
          $display("FAIL rand_io_out got=%h want=%h", bus.io_out, m_io);
        end
`endif
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b0;
    drive(32'h0, 3'd2, 1'b0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    test_reset();
    test_directed();
    test_faults();
    test_reset_midsweep();
    test_mmio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
